multicycle_controller: RTL

Main sequencer for the multicycle ARM datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It decodes the instruction fields into datapath mux selects and ALU control, and owns the architectural NZCV flag register. Each architectural write strobe is gated by the instruction's condition field. The block sits between the instruction register and the shared register file, ALU and unified memory, and is the only source of their enables.

---
 rtl/arm_ctrl_pkg.sv | 61 ++++++
 rtl/cond_eval.sv | 36 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, datapath
// select codes, ALU controls, opcode classes and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check of Cond against the {N,Z,C,V} flags.
module cond_eval
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencer: FSM, datapath select decode, ALU decode, NZCV flag
// register and condition gating of every architectural write strobe.
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    state_e     state_q, state_d, cur_state;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic       next_pc, ir_w, reg_w, mem_w, branch, alu_op;
    logic [1:0] flag_w;
    logic       cond_ex, cond_gate, in_exec;

    // Selects decode as FETCH while Reset is high; strobes are forced low below.
    assign cur_state = Reset ? S_FETCH : state_q;
    assign in_exec   = (cur_state == S_EXECUTER) || (cur_state == S_EXECUTEI);

    cond_eval u_cond_eval (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        next_pc   = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        state_d   = S_FETCH;
        case (cur_state)
            S_FETCH: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                CMD_ADD: begin
                    ALUControl = ALU_ADD;
                    flag_w     = {Funct[0], Funct[0]};
                end
                CMD_SUB: begin
                    ALUControl = ALU_SUB;
                    flag_w     = {Funct[0], Funct[0]};
                end
                CMD_AND: begin
                    ALUControl = ALU_AND;
                    flag_w     = {Funct[0], 1'b0};
                end
                CMD_ORR: begin
                    ALUControl = ALU_ORR;
                    flag_w     = {Funct[0], 1'b0};
                end
                default: begin
                    ALUControl = ALU_ADD;
                    flag_w     = 2'b00;
                end
            endcase
        end
    end

    // ALUWB must not see the flags its own EXECUTE just wrote, so it uses the held CondEx.
    assign cond_gate = (cur_state == S_ALUWB) ? condex_q : cond_ex;

    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        if (in_exec) begin
            condex_d = cond_ex;
            if (cond_ex) begin
                if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
                if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign PCWrite  = ~Reset & (next_pc | (branch & cond_gate));
    assign IRWrite  = ~Reset & ir_w;
    assign RegWrite = ~Reset & reg_w & cond_gate;
    assign MemWrite = ~Reset & mem_w & cond_gate;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == OP_MEM, Op == OP_BR};
    assign State    = state_q;

endmodule
